// File: rtl/seg7_scroll_display.sv
// seg7_scroll_display
// Scrolling seven-segment display driven by a PIO segment port. Every new
// pattern on seg_in is shifted into digit 0. Older digits move one place to
// the left, and the leftmost digit is discarded.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   seg_in     segment pattern, bit i = segment i, 1 = lit
//   clear      synchronous clear of all digits and the fill count
//   blink_en   request blinking of the whole display
//   hex_out    digit k on bits [7k+6:7k], digit 0 is rightmost (registered)
//   new_digit  one-cycle pulse after each shift
//   fill_level digits loaded since reset/clear, saturating at NUM_DIGITS
//
// Optional feature macro: SEG7_SCROLL_BLINK_EN
//   When it is defined, a free-running blink prescaler is built in and it
//   blanks the display while blink_en is high.
//   When it is undefined, blink_en is ignored.

module seg7_scroll_display #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [6:0]              seg_in,
    input  logic                    clear,
    input  logic                    blink_en,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    new_digit,
    output logic [3:0]              fill_level
);

    localparam int         DW       = 7 * NUM_DIGITS;
    localparam logic [3:0] FILL_MAX = 4'(NUM_DIGITS);

    logic [6:0]    seg_q;
    logic [DW-1:0] digits;
    logic [DW-1:0] digits_next;
    logic [DW-1:0] hex_next;
    logic          change;
    logic          blank;

    // A rewrite of the same pattern is not a new digit.
    assign change = (seg_in != seg_q);

    always_comb begin
        digits_next = digits;
        if (clear) begin
            digits_next = '0;
        end else if (change) begin
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                digits_next[7*k +: 7] = digits[7*(k-1) +: 7];
            end
            digits_next[6:0] = seg_in;
        end
    end

`ifdef SEG7_SCROLL_BLINK_EN
    localparam int CW = $clog2(BLINK_DIV);

    logic [CW-1:0] blink_cnt;
    logic          blink_phase;
    logic          blink_wrap;

    assign blink_wrap = (blink_cnt == CW'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // hex_out is registered, so the mask uses the phase that becomes current
    // on this edge. This keeps the display in step with blink_phase.
    assign blank = blink_en & (blink_wrap ? ~blink_phase : blink_phase);
`else
    logic unused_blink;
    localparam int UNUSED_BLINK_DIV = BLINK_DIV;
    assign unused_blink = blink_en ^ UNUSED_BLINK_DIV[0];
    assign blank        = 1'b0;
`endif

    // The output register is loaded from the next digit state. This means a
    // shift shows up on hex_out after the same edge that performs it.
    always_comb begin
        hex_next = digits_next;
        if (blank) begin
            hex_next = '0;
        end
        if (ACTIVE_LOW != 0) begin
            hex_next = ~hex_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q      <= '0;
            digits     <= '0;
            fill_level <= '0;
            new_digit  <= 1'b0;
            hex_out    <= (ACTIVE_LOW != 0) ? {DW{1'b1}} : {DW{1'b0}};
        end else begin
            seg_q   <= seg_in;
            digits  <= digits_next;
            hex_out <= hex_next;
            if (clear) begin
                fill_level <= '0;
                new_digit  <= 1'b0;
            end else if (change) begin
                new_digit <= 1'b1;
                if (fill_level < FILL_MAX) begin
                    fill_level <= fill_level + 4'd1;
                end
            end else begin
                new_digit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scroll_display.sv
// tb_seg7_scroll_display
// Directed bench for seg7_scroll_display.
// The DUT is built with NUM_DIGITS=6, BLINK_DIV=4 and ACTIVE_LOW=1.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_seg7_scroll_display;

    localparam int N  = 6;
    localparam int DW = 7 * N;

    logic          clk;
    logic          reset_n;
    logic [6:0]    seg_in;
    logic          clear;
    logic          blink_en;
    logic [DW-1:0] hex_out;
    logic          new_digit;
    logic [3:0]    fill_level;

    int checks = 0;
    int errors = 0;

    seg7_scroll_display #(
        .NUM_DIGITS(N),
        .BLINK_DIV (4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seg_in    (seg_in),
        .clear     (clear),
        .blink_en  (blink_en),
        .hex_out   (hex_out),
        .new_digit (new_digit),
        .fill_level(fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [6:0]    pats [7];
    logic [DW-1:0] exp_hex;
    logic [DW-1:0] held_hex;
    logic [DW-1:0] contents;
    logic [DW-1:0] samples [16];
    int            pulses;
    int            bad;

    initial begin
        pats[0] = 7'h01; pats[1] = 7'h02; pats[2] = 7'h04; pats[3] = 7'h08;
        pats[4] = 7'h10; pats[5] = 7'h20; pats[6] = 7'h40;

        reset_n  = 1'b0;
        seg_in   = 7'h00;
        clear    = 1'b0;
        blink_en = 1'b0;
        tick();
        tick();
        chk("rst_hex",  64'(hex_out),    64'({DW{1'b1}}));
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_nd",   64'(new_digit),  64'd0);

        // Release reset while seg_in is nonzero.
        seg_in = 7'h3F;
        tick();
        reset_n = 1'b1;
        tick();
        chk("rel_d0",   64'(hex_out[6:0]),  64'h40);
        chk("rel_hi",   64'(hex_out[DW-1:7]), 64'({(DW-7){1'b1}}));
        chk("rel_fill", 64'(fill_level),    64'd1);
        chk("rel_nd",   64'(new_digit),     64'd1);
        tick();
        chk("rel_nd2",  64'(new_digit),     64'd0);
        chk("rel_fill2", 64'(fill_level),   64'd1);

        // Clear with no input change.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_hex",  64'(hex_out),    64'({DW{1'b1}}));
        chk("clr_fill", 64'(fill_level), 64'd0);

        // Load three digits on back-to-back edges.
        seg_in = 7'h06; tick(); chk("b2b_nd0", 64'(new_digit), 64'd1);
        seg_in = 7'h5B; tick(); chk("b2b_nd1", 64'(new_digit), 64'd1);
        seg_in = 7'h4F; tick(); chk("b2b_nd2", 64'(new_digit), 64'd1);
        chk("b2b_hex",  64'(hex_out), 64'({21'h1FFFFF, 7'h79, 7'h24, 7'h30}));
        chk("b2b_fill", 64'(fill_level), 64'd3);
        tick();
        chk("b2b_nd3",  64'(new_digit), 64'd0);

        // Overflow with seven distinct patterns.
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 7; i++) begin
            seg_in = pats[i];
            tick();
            chk("ovf_nd",   64'(new_digit),  64'd1);
            chk("ovf_fill", 64'(fill_level), 64'((i + 1 > N) ? N : i + 1));
        end
        exp_hex = '1;
        for (int k = 0; k < N; k++) exp_hex[7*k +: 7] = ~pats[6-k];
        chk("ovf_hex", 64'(hex_out), 64'(exp_hex));
        chk("ovf_d5",  64'(hex_out[41:35]), 64'h7D);

        // Hold the same value for 100 cycles.
        held_hex = hex_out;
        pulses   = 0;
        bad      = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (new_digit) pulses++;
            if (hex_out !== held_hex) bad++;
        end
        chk("hold_nd",   64'(pulses), 64'd0);
        chk("hold_hex",  64'(bad),    64'd0);
        chk("hold_fill", 64'(fill_level), 64'd6);

        // Assert clear in the same cycle as a change, then release it.
        seg_in = 7'h7F;
        clear  = 1'b1;
        tick();
        clear  = 1'b0;
        chk("clrc_hex",  64'(hex_out),    64'({DW{1'b1}}));
        chk("clrc_fill", 64'(fill_level), 64'd0);
        chk("clrc_nd",   64'(new_digit),  64'd0);
        tick();
        chk("clrr_nd",   64'(new_digit),  64'd0);
        chk("clrr_fill", 64'(fill_level), 64'd0);
        chk("clrr_hex",  64'(hex_out),    64'({DW{1'b1}}));

        // Load contents for the blink test.
        seg_in = 7'h06; tick();
        seg_in = 7'h5B; tick();
        contents = {28'hFFFFFFF, 7'h79, 7'h24};
        chk("pre_hex",  64'(hex_out),    64'(contents));
        chk("pre_fill", 64'(fill_level), 64'd2);

        blink_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            samples[i] = hex_out;
        end
`ifdef SEG7_SCROLL_BLINK_EN
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (samples[i] !== contents && samples[i] !== {DW{1'b1}}) bad++;
        end
        chk("blink_vals", 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (samples[i] === samples[i+4]) bad++;
        end
        chk("blink_alt", 64'(bad), 64'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (samples[i] !== samples[i+8]) bad++;
        end
        chk("blink_per", 64'(bad), 64'd0);
`else
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (samples[i] !== contents) bad++;
        end
        chk("noblink", 64'(bad), 64'd0);
`endif
        blink_en = 1'b0;
        tick();
        chk("unblink_hex", 64'(hex_out), 64'(contents));
        chk("unblink_fill", 64'(fill_level), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
